// File: rtl/lru_victim_ctrl.sv
// LRU victim controller: looks up a captured 8-way tag/valid/age snapshot,
// reports hits, picks a refill victim on a miss, waits for the refill with a
// bounded timeout and issues a one-cycle LRU age-tracker update.
// Optional build macro: LRU_VICTIM_INVALID_FIRST_EN (prefer invalid ways as
// victims and promote them on fill).
module lru_victim_ctrl #(
    parameter logic [7:0] REFILL_TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [7:0]  i_tag_match_8,
    input  logic [7:0]  i_valid_8,
    input  logic [23:0] i_age_24,
    output logic        o_hit,
    output logic        o_refill_req,
    output logic [7:0]  o_victim_way_8,
    input  logic        i_refill_done,
    output logic        o_timeout,
    output logic        o_multi_hit,
    output logic [7:0]  o_lru_hit_way_8,
    output logic        o_lru_write_enable,
    output logic        o_lru_hit_sig
);

    typedef enum logic [1:0] {StIdle, StLookup, StRefill, StUpdate} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  match_q, match_d;
    logic [7:0]  valid_q, valid_d;
    logic [23:0] age_q, age_d;
    logic [7:0]  victim_q, victim_d;
    logic        fill_sig_q, fill_sig_d;
    logic        hit_q, hit_d;
    logic        multi_q, multi_d;
    logic        we_q, we_d;
    logic [7:0]  way_q, way_d;
    logic        sig_q, sig_d;
    logic        refill_q, refill_d;
    logic        timeout_q, timeout_d;

    logic [7:0]  hit_vec;
    logic [7:0]  hit_sel;
    logic [7:0]  age_sel;
`ifdef LRU_VICTIM_INVALID_FIRST_EN
    logic [7:0]  inv_sel;
`endif

    // Priority pickers over the captured snapshot; the downward loop leaves the lowest index.
    always_comb begin
        hit_vec = match_q & valid_q;
        hit_sel = 8'h00;
        age_sel = 8'h01;  // no age-0 way falls back to way 0
`ifdef LRU_VICTIM_INVALID_FIRST_EN
        inv_sel = 8'h00;
`endif
        for (int i = 7; i >= 0; i--) begin
            if (hit_vec[i]) hit_sel = 8'b1 << i;
            if (age_q[3*i +: 3] == 3'b000) age_sel = 8'b1 << i;
`ifdef LRU_VICTIM_INVALID_FIRST_EN
            if (!valid_q[i]) inv_sel = 8'b1 << i;
`endif
        end
    end

    // Next-state and registered-output logic; pulse outputs default low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        valid_d    = valid_q;
        age_d      = age_q;
        victim_d   = victim_q;
        fill_sig_d = fill_sig_q;
        refill_d   = refill_q;
        hit_d      = 1'b0;
        multi_d    = 1'b0;
        we_d       = 1'b0;
        way_d      = 8'h00;
        sig_d      = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    match_d = i_tag_match_8;
                    valid_d = i_valid_8;
                    age_d   = i_age_24;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit_vec != 8'h00) begin
                    state_d = StUpdate;
                    hit_d   = 1'b1;
                    we_d    = 1'b1;
                    way_d   = hit_sel;
                    sig_d   = 1'b1;
                    multi_d = (hit_vec & (hit_vec - 8'd1)) != 8'h00;
                end else begin
                    state_d  = StRefill;
                    refill_d = 1'b1;
                    cnt_d    = 8'd0;
`ifdef LRU_VICTIM_INVALID_FIRST_EN
                    victim_d   = (inv_sel != 8'h00) ? inv_sel : age_sel;
                    fill_sig_d = (inv_sel != 8'h00);
`else
                    victim_d   = age_sel;
                    fill_sig_d = 1'b0;
`endif
                end
            end
            StRefill: begin
                // done takes priority over an expiring timeout in the same cycle
                if (i_refill_done) begin
                    state_d  = StUpdate;
                    we_d     = 1'b1;
                    way_d    = victim_q;
                    sig_d    = fill_sig_q;
                    refill_d = 1'b0;
                    victim_d = 8'h00;
                end else if (cnt_q == REFILL_TIMEOUT - 8'd1) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                    refill_d  = 1'b0;
                    victim_d  = 8'h00;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StUpdate: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            match_q    <= 8'h00;
            valid_q    <= 8'h00;
            age_q      <= 24'h0;
            victim_q   <= 8'h00;
            fill_sig_q <= 1'b0;
            hit_q      <= 1'b0;
            multi_q    <= 1'b0;
            we_q       <= 1'b0;
            way_q      <= 8'h00;
            sig_q      <= 1'b0;
            refill_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            valid_q    <= valid_d;
            age_q      <= age_d;
            victim_q   <= victim_d;
            fill_sig_q <= fill_sig_d;
            hit_q      <= hit_d;
            multi_q    <= multi_d;
            we_q       <= we_d;
            way_q      <= way_d;
            sig_q      <= sig_d;
            refill_q   <= refill_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_req_ready        = (state_q == StIdle);
    assign o_hit              = hit_q;
    assign o_multi_hit        = multi_q;
    assign o_lru_write_enable = we_q;
    assign o_lru_hit_way_8    = way_q;
    assign o_lru_hit_sig      = sig_q;
    assign o_refill_req       = refill_q;
    assign o_victim_way_8     = victim_q;
    assign o_timeout          = timeout_q;

endmodule

// File: tb/tb_lru_victim_ctrl.sv
// Self-checking bench for lru_victim_ctrl: table of lookup vectors run through
// a scoreboard queue, plus hand-written reset and stray-done sequences.
module tb_lru_victim_ctrl;

    localparam logic [7:0] TO = 8'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [7:0]  i_tag_match_8;
    logic [7:0]  i_valid_8;
    logic [23:0] i_age_24;
    logic        o_hit;
    logic        o_refill_req;
    logic [7:0]  o_victim_way_8;
    logic        i_refill_done;
    logic        o_timeout;
    logic        o_multi_hit;
    logic [7:0]  o_lru_hit_way_8;
    logic        o_lru_write_enable;
    logic        o_lru_hit_sig;

    lru_victim_ctrl #(.REFILL_TIMEOUT(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_tag_match_8      (i_tag_match_8),
        .i_valid_8          (i_valid_8),
        .i_age_24           (i_age_24),
        .o_hit              (o_hit),
        .o_refill_req       (o_refill_req),
        .o_victim_way_8     (o_victim_way_8),
        .i_refill_done      (i_refill_done),
        .o_timeout          (o_timeout),
        .o_multi_hit        (o_multi_hit),
        .o_lru_hit_way_8    (o_lru_hit_way_8),
        .o_lru_write_enable (o_lru_write_enable),
        .o_lru_hit_sig      (o_lru_hit_sig)
    );

    always #5 clk = ~clk;

    // kind: 0 hit update, 1 fill update, 2 timeout
    typedef struct {
        logic [7:0]  match;
        logic [7:0]  valid;
        logic [23:0] age;
        int          done_after;
        int          kind;
        logic [7:0]  exp_way;
        logic        exp_sig;
        logic        exp_multi;
        logic [7:0]  exp_victim;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Ways set in zmask get age 0, all others 3'b110.
    function automatic logic [23:0] age_zero(input logic [7:0] zmask);
        logic [23:0] a;
        for (int k = 0; k < 8; k++) a[3*k +: 3] = zmask[k] ? 3'b000 : 3'b110;
        return a;
    endfunction

    function automatic vec_t mk(input logic [7:0] m, input logic [7:0] v, input logic [23:0] a,
                                input int da, input int kind, input logic [7:0] way,
                                input logic sig, input logic multi, input logic [7:0] vic);
        vec_t r;
        r.match = m; r.valid = v; r.age = a; r.done_after = da; r.kind = kind;
        r.exp_way = way; r.exp_sig = sig; r.exp_multi = multi; r.exp_victim = vic;
        return r;
    endfunction

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        chk1({tag, "_ready_again"}, o_req_ready, 1'b1);
        chk1({tag, "_we_low"}, o_lru_write_enable, 1'b0);
        chk8({tag, "_way_zero"}, o_lru_hit_way_8, 8'h00);
        chk1({tag, "_timeout_low"}, o_timeout, 1'b0);
        chk1({tag, "_hit_low"}, o_hit, 1'b0);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   n;
        int   rc;
        bit   seen;
        vec_t e;
        @(negedge clk);
        chk1({tag, "_ready_before"}, o_req_ready, 1'b1);
        i_req_valid   = 1'b1;
        i_tag_match_8 = v.match;
        i_valid_8     = v.valid;
        i_age_24      = v.age;
        exp_q.push_back(v);
        @(negedge clk);
        // inputs are cleared so that only the captured snapshot can be used
        i_req_valid   = 1'b0;
        i_tag_match_8 = 8'h00;
        i_valid_8     = 8'h00;
        i_age_24      = 24'h0;
        chk1({tag, "_lookup_not_ready"}, o_req_ready, 1'b0);
        n = 0; rc = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            i_refill_done = 1'b0;
            if (n == 1) chk1({tag, "_latency"}, o_refill_req | o_lru_write_enable, 1'b1);
            if (o_lru_write_enable || o_timeout) begin
                seen = 1;
                e = exp_q.pop_front();
                chk1({tag, "_timeout"}, o_timeout, e.kind == 2);
                chk1({tag, "_we"}, o_lru_write_enable, e.kind != 2);
                chk1({tag, "_hit"}, o_hit, e.kind == 0);
                chk8({tag, "_way"}, o_lru_hit_way_8, (e.kind == 2) ? 8'h00 : e.exp_way);
                chk1({tag, "_sig"}, o_lru_hit_sig, (e.kind == 2) ? 1'b0 : e.exp_sig);
                chk1({tag, "_multi"}, o_multi_hit, e.exp_multi);
                chk1({tag, "_refill_off"}, o_refill_req, 1'b0);
                chk8({tag, "_victim_cleared"}, o_victim_way_8, 8'h00);
                chk1({tag, "_ready_at_event"}, o_req_ready, e.kind == 2);
                if (e.kind == 2) chk8({tag, "_timeout_cycles"}, 8'(rc), TO);
            end else if (o_refill_req) begin
                chk8({tag, "_victim"}, o_victim_way_8, v.exp_victim);
                if (rc == v.done_after) i_refill_done = 1'b1;
                rc++;
            end
        end
        i_refill_done = 1'b0;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_no_completion: got none, required strobe or timeout", tag);
            void'(exp_q.pop_front());
        end
        check_idle_after(tag);
    endtask

    initial begin
        vecs[0] = mk(8'h04, 8'hFF, age_zero(8'h00), -1, 0, 8'h04, 1'b1, 1'b0, 8'h00);
        vecs[1] = mk(8'h81, 8'hFF, age_zero(8'h00), -1, 0, 8'h01, 1'b1, 1'b1, 8'h00);
        vecs[2] = mk(8'h0C, 8'hF7, age_zero(8'h00), -1, 0, 8'h04, 1'b1, 1'b0, 8'h00);
        vecs[3] = mk(8'h30, 8'hFF, age_zero(8'h00), -1, 0, 8'h10, 1'b1, 1'b1, 8'h00);
        vecs[4] = mk(8'h00, 8'hFF, age_zero(8'h20), 2, 1, 8'h20, 1'b0, 1'b0, 8'h20);
        vecs[5] = mk(8'h00, 8'hFF, age_zero(8'h00), 0, 1, 8'h01, 1'b0, 1'b0, 8'h01);
        vecs[6] = mk(8'h00, 8'hFF, age_zero(8'h44), 1, 1, 8'h04, 1'b0, 1'b0, 8'h04);
        vecs[7] = mk(8'h00, 8'hFF, age_zero(8'h80), -1, 2, 8'h00, 1'b0, 1'b0, 8'h80);
        vecs[8] = mk(8'h00, 8'hFF, age_zero(8'h08), 3, 1, 8'h08, 1'b0, 1'b0, 8'h08);
`ifdef LRU_VICTIM_INVALID_FIRST_EN
        vecs[9] = mk(8'h00, 8'hF7, age_zero(8'h20), 1, 1, 8'h08, 1'b1, 1'b0, 8'h08);
`else
        vecs[9] = mk(8'h00, 8'hF7, age_zero(8'h20), 1, 1, 8'h20, 1'b0, 1'b0, 8'h20);
`endif

        rst = 1'b1;
        i_req_valid = 1'b0;
        i_tag_match_8 = 8'h00;
        i_valid_8 = 8'h00;
        i_age_24 = 24'h0;
        i_refill_done = 1'b0;
        #12;
        chk1("rst_ready", o_req_ready, 1'b1);
        chk1("rst_we", o_lru_write_enable, 1'b0);
        chk1("rst_refill", o_refill_req, 1'b0);
        chk8("rst_victim", o_victim_way_8, 8'h00);
        chk8("rst_way", o_lru_hit_way_8, 8'h00);
        chk1("rst_timeout", o_timeout, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Stray refill_done while idle and during lookup must be ignored.
        @(negedge clk);
        i_refill_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("stray_done_idle_we", o_lru_write_enable, 1'b0);
            chk1("stray_done_idle_ready", o_req_ready, 1'b1);
        end
        i_req_valid = 1'b1;
        i_valid_8 = 8'hFF;
        i_age_24 = age_zero(8'h02);
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        chk1("stray_done_lookup_refill", o_refill_req, 1'b1);
        chk1("stray_done_lookup_we", o_lru_write_enable, 1'b0);
        chk8("stray_done_victim", o_victim_way_8, 8'h02);
        @(negedge clk);
        i_refill_done = 1'b0;
        chk1("stray_done_fill_we", o_lru_write_enable, 1'b1);
        chk8("stray_done_fill_way", o_lru_hit_way_8, 8'h02);
        check_idle_after("stray_done");

        // Reset asserted mid-refill aborts with no strobe.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_tag_match_8 = 8'h00;
        i_valid_8 = 8'hFF;
        i_age_24 = age_zero(8'h20);
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        chk1("rstmid_in_refill", o_refill_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("rstmid_refill_off", o_refill_req, 1'b0);
        chk1("rstmid_ready", o_req_ready, 1'b1);
        chk8("rstmid_victim", o_victim_way_8, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        i_refill_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("rstmid_no_strobe", o_lru_write_enable, 1'b0);
            chk1("rstmid_no_timeout", o_timeout, 1'b0);
        end
        i_refill_done = 1'b0;
        run_txn(vecs[0], "post_rst_hit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

endmodule
